// File: rtl/xor_frame_accum.sv
// xor_frame_accum: folds a valid/ready frame of WIDTH-bit beats into one XOR word, parity bit, beat count and overflow flag (in_*: beat stream, out_*: result)
module xor_frame_accum #(
  parameter int WIDTH = 8,
  parameter int MAXLEN = 16,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}},
  localparam int CW = $clog2(MAXLEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_parity,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);
  typedef enum logic {ACC, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, word_q, word_d, acc_nx;
  logic [CW-1:0] cnt_q, cnt_d, count_q, count_d, cnt_nx;
  logic parity_q, parity_d, ovf_q, ovf_d, take, hit, fin, hs;
  always_comb begin
    in_ready = state_q == ACC;
    out_valid = state_q == DONE;
    take = in_valid & in_ready;
    hs = out_valid & out_ready;
    acc_nx = acc_q ^ in_data;
    cnt_nx = cnt_q + CW'(1);
    hit = cnt_nx == CW'(MAXLEN);
    fin = take & (in_last | hit);
    state_d = fin ? DONE : hs ? ACC : state_q;
    acc_d = hs ? INIT : take ? acc_nx : acc_q;
    cnt_d = hs ? '0 : take ? cnt_nx : cnt_q;
    word_d = fin ? acc_nx : word_q;
    count_d = fin ? cnt_nx : count_q;
    parity_d = fin ? ^acc_nx : parity_q;
    ovf_d = fin ? hit & ~in_last : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q <= INIT;
      cnt_q <= '0;
      word_q <= '0;
      count_q <= '0;
      parity_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      count_q <= count_d;
      parity_q <= parity_d;
      ovf_q <= ovf_d;
    end
  end
  assign out_word = word_q;
  assign out_count = count_q;
  assign out_parity = parity_q;
  assign out_overflow = ovf_q;
endmodule

// File: tb/tb_xor_frame_accum.sv
// tb_xor_frame_accum: randomized scoreboard bench for xor_frame_accum against a frame-level reference model
module tb_xor_frame_accum;
  localparam int W = 8;
  localparam int ML = 4;
  localparam logic [W-1:0] IV = 8'hA5;
  localparam int CW = $clog2(ML + 1);
  typedef struct packed {
    logic [W-1:0] w;
    logic p;
    logic [CW-1:0] c;
    logic o;
  } res_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, out_parity, out_overflow;
  logic [W-1:0] out_word;
  logic [CW-1:0] out_count;
  res_t exp_q[$];
  logic [W-1:0] cur[$];
  res_t got, want, held;
  bit busy = 0, hold = 0, rst_prev = 0;
  int total = 0, bad = 0;
  xor_frame_accum #(.WIDTH(W), .MAXLEN(ML), .INIT(IV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_parity(out_parity), .out_count(out_count), .out_overflow(out_overflow));
  always #5 clk = ~clk;
  function automatic res_t fold(input bit lst);
    res_t r;
    r.w = IV;
    foreach (cur[i]) r.w = r.w ^ cur[i];
    r.p = 1'b0;
    for (int b = 0; b < W; b++) r.p = r.p ^ r.w[b];
    r.c = CW'(cur.size());
    r.o = (cur.size() == ML) && !lst;
    return r;
  endfunction
  always @(negedge clk) begin
    got = '{w: out_word, p: out_parity, c: out_count, o: out_overflow};
    total++;
    if (in_ready !== !busy || out_valid !== busy) begin
      bad++;
      $display("FAIL flags: in_ready=%b out_valid=%b required in_ready=%b out_valid=%b", in_ready, out_valid, !busy, busy);
    end
    if (rst && rst_prev) begin
      total++;
      if ({got, out_valid} !== '0) begin
        bad++;
        $display("FAIL reset_zero: outputs=%h valid=%b required all zero", got, out_valid);
      end
    end
    if (hold) begin
      total++;
      if (!out_valid || got !== held) begin
        bad++;
        $display("FAIL stable: valid=%b out=%h required valid=1 out=%h", out_valid, got, held);
      end
    end
    hold = out_valid && !out_ready && !rst;
    held = got;
    rst_prev = rst;
    if (rst) begin
      cur.delete();
      exp_q.delete();
      busy = 0;
    end else begin
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL spurious: out=%h required no result", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            bad++;
            $display("FAIL result: word=%h par=%b cnt=%0d ovf=%b required word=%h par=%b cnt=%0d ovf=%b",
                     got.w, got.p, got.c, got.o, want.w, want.p, want.c, want.o);
          end
        end
      end
      if (busy) begin
        if (out_ready) busy = 0;
      end else if (in_valid) begin
        cur.push_back(in_data);
        if (in_last || cur.size() == ML) begin
          exp_q.push_back(fold(in_last));
          cur.delete();
          busy = 1;
        end
      end
    end
  end
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data = d;
    in_last = l;
    out_ready = r;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    cyc(1, 8'h0F, 0, 1); cyc(1, 8'hF0, 0, 1); cyc(1, 8'h3C, 1, 1); cyc(0, 8'h00, 0, 1); cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h07, 1, 1); cyc(0, 8'h00, 0, 1); cyc(1, 8'h0F, 1, 1); cyc(0, 8'h00, 0, 1);
    for (int k = 0; k < 4; k++) cyc(1, 8'(1 << k), 0, 1);
    cyc(0, 8'h00, 0, 1);
    for (int k = 0; k < 4; k++) cyc(1, 8'(1 << k), k == 3, 1);
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h5A, 1, 0);
    for (int k = 0; k < 5; k++) cyc(1, 8'h99, 1, 0);
    cyc(1, 8'h33, 1, 1); cyc(1, 8'h44, 1, 1); cyc(0, 8'h00, 0, 1);
    cyc(1, 8'hAA, 0, 1);
    for (int k = 0; k < 3; k++) cyc(0, 8'($urandom), 1'($urandom), 1);
    cyc(1, 8'h55, 1, 1); cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h11, 0, 1); cyc(1, 8'h22, 0, 1);
    @(posedge clk); #1 rst = 1; in_valid = 0;
    cyc(0, 8'h00, 0, 1);
    #0 rst = 0;
    cyc(1, 8'h80, 1, 1); cyc(0, 8'h00, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0);
      rst = $urandom_range(0, 149) == 0;
    end
    cyc(0, 8'h00, 0, 1);
    rst = 0;
    repeat (6) cyc(0, 8'h00, 0, 1);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0 || busy) begin
      bad++;
      $display("FAIL drain: pending=%0d busy=%b required pending=0 busy=0", exp_q.size(), busy);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
